axis_testpattern_checker: RTL and testbench
===========================================

// Module: axis_testpattern_checker
// PURPOSE
//   AXI-Stream slave that consumes the counter stream produced by the test pattern generator.
//   It checks every accepted beat against the generator's sequence rule.
//   It reports lock, single-cycle error pulses and saturating error/beat counters for link bring-up.
//   It sits at the far end of a DMA/FIFO/interconnect path under test and throttles via tready.
// PARAMETERS
//   S00_AXIS_TDATA_WIDTH  32   stream data width
//   COUNTER_START         0    first value of the sequence
//   COUNTER_END           255  wrap threshold
//   COUNTER_INCR          1    step between consecutive values
//   READY_DIVIDER         0    0: tready always high when enabled; N>0: tready high 1 of every N+1 cycles
//   LOCK_LOSS             4    consecutive mismatches that drop lock (>=1)
//   CNT_WIDTH             32   width of error_count and beat_count
// PORTS
//   s_axis_aclk     in   1          clock, all logic on rising edge
//   s_axis_areset   in   1          synchronous, active-high reset
//   enable          in   1          checker enable; low forces tready low and returns to ACQUIRE
//   clear_counters  in   1          synchronous clear of error_count/beat_count
//   s_axis_tdata    in   S00_AXIS_TDATA_WIDTH  received pattern word
//   s_axis_tvalid   in   1          beat valid
//   s_axis_tready   out  1          beat accepted when tvalid&tready
//   locked          out  1          sequence tracked
//   error_pulse     out  1          one-cycle strobe per mismatching beat
//   error_count     out  CNT_WIDTH  mismatches since reset/clear, saturating
//   beat_count      out  CNT_WIDTH  accepted beats since reset/clear, saturating
//   last_data       out  S00_AXIS_TDATA_WIDTH  last accepted tdata
// BEHAVIOUR
//   Reset (sync, high): tready=0, locked=0, error_pulse=0, counters=0, last_data=COUNTER_START, state=ACQUIRE, ready divider=0.
//   next(v): v>=COUNTER_END ? v-(COUNTER_END-COUNTER_START) : v+COUNTER_INCR, computed in tdata width.
//     Identical to the generator's rule, including overshoot when INCR does not land exactly on END.
//   Valid range: COUNTER_START <= v <= COUNTER_END+COUNTER_INCR-1.
//   tready: registered.
//     Low while enable=0.
//     With READY_DIVIDER=0, high from the cycle after enable rises.
//     Else a down-counter reloads READY_DIVIDER at zero; tready=1 only in the zero cycle.
//     tready never depends combinationally on tvalid.
//   Beat = tvalid&tready in a cycle. All outputs update 1 cycle after the beat (registered).
//   beat_count++ on every beat; last_data<=tdata.
//   ACQUIRE: beat with tdata in valid range -> expected<=next(tdata), LOCKED, locked=1.
//     Beat out of range -> stay ACQUIRE, no error counted.
//   LOCKED: tdata==expected -> expected<=next(tdata), miss counter=0.
//     Mismatch -> error_pulse=1, error_count++, expected<=next(tdata) (resync, so a dropped beat costs exactly one error), miss counter++.
//     miss counter reaching LOCK_LOSS -> ACQUIRE, locked=0.
//   enable falling: state<=ACQUIRE, locked<=0, counters held, tready<=0 next cycle.
//     A beat in the same cycle enable falls is still checked.
//   clear_counters concurrent with a beat: clear wins, counters end at 0; error_pulse still fires.
//   Saturation: counters stick at all-ones.
//   Reset mid-stream: everything returns to reset values next cycle; in-flight beat is not counted.
// STRUCTURE
//   Package axis_tp_pkg: next-value rule as a function (shared with generator), state encoding localparams (ACQUIRE, LOCKED).
//   One sub-module: axis_tp_ready_throttle (READY_DIVIDER down-counter -> tready); rest stays flat.
// TESTING
//   1 Default params, tvalid=1 stream 0..255,0..: locked=1 one cycle after first beat; error_count stays 0; beat_count=512 after 512 beats.
//   2 Drop value 17 (send 16,18,19): one error_pulse, error_count=1, locked stays 1, 19 accepted cleanly.
//   3 INCR=7, END=20, START=0: sequence 0,7,14,21,1,8,... checked with no errors (overshoot wrap).
//   4 Four consecutive garbage words 0xDEAD: error_count=4, locked falls after the 4th; then 5,6,7 -> relock after 5, no further errors.
//   5 READY_DIVIDER=3: tready high exactly every 4th cycle; generator paced stream checks clean, beat_count=100 after 400 cycles.
//   6 clear_counters together with a mismatch: error_count=0, error_pulse=1.
//     Reset asserted mid-stream: all outputs at reset values next cycle.

Source files
------------

// File: rtl/axis_tp_pkg.sv
// rtl/axis_tp_pkg.sv - shared sequence rule and state encoding for the test pattern checker
package axis_tp_pkg;

  localparam logic TP_ACQUIRE = 1'b0;
  localparam logic TP_LOCKED  = 1'b1;

  typedef enum logic {
    ACQUIRE = TP_ACQUIRE,
    LOCKED  = TP_LOCKED
  } tp_state_e;

  // Generator's successor rule. Evaluated on 64-bit operands; callers truncate to
  // their data width, which gives the same result as doing the arithmetic at that width.
  function automatic logic [63:0] tp_next(input logic [63:0] v,
                                          input logic [63:0] start_v,
                                          input logic [63:0] end_v,
                                          input logic [63:0] incr_v);
    return (v >= end_v) ? (v - (end_v - start_v)) : (v + incr_v);
  endfunction

endpackage

// File: rtl/axis_tp_ready_throttle.sv
// rtl/axis_tp_ready_throttle.sv - registered tready pacing with optional 1-in-(N+1) duty
module axis_tp_ready_throttle #(
  parameter int READY_DIVIDER = 0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_tready
);

  logic r_tready;

  generate
    if (READY_DIVIDER == 0) begin : g_always_ready
      // tready simply follows enable one cycle later
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_tready <= 1'b0;
        end else begin
          r_tready <= i_enable;
        end
      end
    end else begin : g_divided_ready
      localparam int DIV_W = $clog2(READY_DIVIDER + 1);
      localparam logic [DIV_W-1:0] RELOAD = DIV_W'(READY_DIVIDER);

      logic [DIV_W-1:0] r_cnt;

      // down-counter: tready is asserted for the one cycle that follows the zero count
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_cnt    <= '0;
          r_tready <= 1'b0;
        end else if (!i_enable) begin
          r_cnt    <= '0;
          r_tready <= 1'b0;
        end else begin
          r_tready <= (r_cnt == '0);
          r_cnt    <= (r_cnt == '0) ? RELOAD : (r_cnt - 1'b1);
        end
      end
    end
  endgenerate

  assign o_tready = r_tready;

endmodule

// File: rtl/axis_testpattern_checker.sv
// rtl/axis_testpattern_checker.sv - AXI-Stream counter pattern checker with lock and error counters
module axis_testpattern_checker
  import axis_tp_pkg::*;
#(
  parameter int S00_AXIS_TDATA_WIDTH = 32,
  parameter int COUNTER_START        = 0,
  parameter int COUNTER_END          = 255,
  parameter int COUNTER_INCR         = 1,
  parameter int READY_DIVIDER        = 0,
  parameter int LOCK_LOSS            = 4,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,
  input  logic                            enable,
  input  logic                            clear_counters,
  input  logic [S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic                            locked,
  output logic                            error_pulse,
  output logic [CNT_WIDTH-1:0]            error_count,
  output logic [CNT_WIDTH-1:0]            beat_count,
  output logic [S00_AXIS_TDATA_WIDTH-1:0] last_data
);

  localparam int W      = S00_AXIS_TDATA_WIDTH;
  localparam int MISS_W = $clog2(LOCK_LOSS + 1);

  localparam logic [63:0]          START64  = 64'(COUNTER_START);
  localparam logic [63:0]          END64    = 64'(COUNTER_END);
  localparam logic [63:0]          INCR64   = 64'(COUNTER_INCR);
  localparam logic [63:0]          RANGE_HI = END64 + INCR64 - 64'd1;
  localparam logic [MISS_W-1:0]    LOSS_M1  = MISS_W'(LOCK_LOSS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [W-1:0]         START_W  = W'(COUNTER_START);

  tp_state_e          r_state;
  tp_state_e          w_state_nxt;
  logic [W-1:0]       r_expected;
  logic [W-1:0]       w_expected_nxt;
  logic [MISS_W-1:0]  r_miss;
  logic [MISS_W-1:0]  w_miss_nxt;
  logic               w_mismatch;
  logic               w_beat;
  logic               w_tready;
  logic               w_in_range;
  logic [63:0]        w_data64;
  logic [W-1:0]       w_next;
  logic               r_error_pulse;
  logic [CNT_WIDTH-1:0] r_error_count;
  logic [CNT_WIDTH-1:0] r_beat_count;
  logic [W-1:0]       r_last_data;

  axis_tp_ready_throttle #(
    .READY_DIVIDER(READY_DIVIDER)
  ) u_throttle (
    .i_clk    (s_axis_aclk),
    .i_reset  (s_axis_areset),
    .i_enable (enable),
    .o_tready (w_tready)
  );

  assign w_beat     = s_axis_tvalid & w_tready;
  assign w_data64   = 64'(s_axis_tdata);
  assign w_next     = W'(tp_next(w_data64, START64, END64, INCR64));
  assign w_in_range = (w_data64 >= START64) && (w_data64 <= RANGE_HI);

  // sequence state and miss-run register
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_state    <= ACQUIRE;
      r_expected <= START_W;
      r_miss     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_expected <= w_expected_nxt;
      r_miss     <= w_miss_nxt;
    end
  end

  // acquire/track decision per accepted beat; a mismatch resyncs to the received word
  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_miss_nxt     = r_miss;
    w_mismatch     = 1'b0;
    if (w_beat) begin
      case (r_state)
        ACQUIRE: begin
          if (w_in_range) begin
            w_expected_nxt = w_next;
            w_state_nxt    = LOCKED;
            w_miss_nxt     = '0;
          end
        end
        LOCKED: begin
          w_expected_nxt = w_next;
          if (s_axis_tdata == r_expected) begin
            w_miss_nxt = '0;
          end else begin
            w_mismatch = 1'b1;
            if (r_miss >= LOSS_M1) begin
              w_state_nxt = ACQUIRE;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = r_miss + 1'b1;
            end
          end
        end
        default: w_state_nxt = ACQUIRE;
      endcase
    end
    // dropping enable always returns to acquisition, after the beat above is checked
    if (!enable) begin
      w_state_nxt = ACQUIRE;
      w_miss_nxt  = '0;
    end
  end

  // saturating counters, error strobe and captured word; clear beats a concurrent increment
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_error_pulse <= 1'b0;
      r_error_count <= '0;
      r_beat_count  <= '0;
      r_last_data   <= START_W;
    end else begin
      r_error_pulse <= w_mismatch;
      if (w_beat) begin
        r_last_data <= s_axis_tdata;
      end
      if (clear_counters) begin
        r_error_count <= '0;
        r_beat_count  <= '0;
      end else begin
        if (w_beat && (r_beat_count != CNT_MAX)) begin
          r_beat_count <= r_beat_count + 1'b1;
        end
        if (w_mismatch && (r_error_count != CNT_MAX)) begin
          r_error_count <= r_error_count + 1'b1;
        end
      end
    end
  end

  assign s_axis_tready = w_tready;
  assign locked        = (r_state == LOCKED);
  assign error_pulse   = r_error_pulse;
  assign error_count   = r_error_count;
  assign beat_count    = r_beat_count;
  assign last_data     = r_last_data;

endmodule

// File: tb/tb_axis_testpattern_checker.sv
// tb/tb_axis_testpattern_checker.sv - scoreboard bench for axis_testpattern_checker
module tb_axis_testpattern_checker;

  typedef struct packed {
    logic        lk;
    logic        ep;
    logic [31:0] ec;
    logic [31:0] bc;
    logic [31:0] ld;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  en = 3'b000;
  logic [2:0]  clr = 3'b000;
  logic [2:0]  tvalid = 3'b000;
  logic [31:0] td [3];
  logic [2:0]  tready;
  logic [2:0]  lk;
  logic [2:0]  ep;
  logic [31:0] ec [3];
  logic [31:0] bc [3];
  logic [31:0] ld [3];

  exp_t        sbq [3][$];
  exp_t        mon_e;
  logic [2:0]  pend = 3'b000;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          prev_cyc = 0;
  bit          have_prev = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: defaults
  axis_testpattern_checker u_def (
    .s_axis_aclk(clk), .s_axis_areset(rst[0]), .enable(en[0]), .clear_counters(clr[0]),
    .s_axis_tdata(td[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
    .locked(lk[0]), .error_pulse(ep[0]), .error_count(ec[0]), .beat_count(bc[0]),
    .last_data(ld[0])
  );

  // instance 1: overshoot wrap
  axis_testpattern_checker #(.COUNTER_END(20), .COUNTER_INCR(7)) u_wrap (
    .s_axis_aclk(clk), .s_axis_areset(rst[1]), .enable(en[1]), .clear_counters(clr[1]),
    .s_axis_tdata(td[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
    .locked(lk[1]), .error_pulse(ep[1]), .error_count(ec[1]), .beat_count(bc[1]),
    .last_data(ld[1])
  );

  // instance 2: throttled ready
  axis_testpattern_checker #(.READY_DIVIDER(3)) u_thr (
    .s_axis_aclk(clk), .s_axis_areset(rst[2]), .enable(en[2]), .clear_counters(clr[2]),
    .s_axis_tdata(td[2]), .s_axis_tvalid(tvalid[2]), .s_axis_tready(tready[2]),
    .locked(lk[2]), .error_pulse(ep[2]), .error_count(ec[2]), .beat_count(bc[2]),
    .last_data(ld[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: outputs presented one cycle after a beat are compared with the queued result
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pend[i]) begin
        if (sbq[i].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL u%0d_sb_underflow: got beat expected none", i);
        end else begin
          mon_e = sbq[i].pop_front();
          chk($sformatf("u%0d_locked", i), 32'(lk[i]), 32'(mon_e.lk));
          chk($sformatf("u%0d_error_pulse", i), 32'(ep[i]), 32'(mon_e.ep));
          chk($sformatf("u%0d_error_count", i), ec[i], mon_e.ec);
          chk($sformatf("u%0d_beat_count", i), bc[i], mon_e.bc);
          chk($sformatf("u%0d_last_data", i), ld[i], mon_e.ld);
        end
      end
      pend[i] = tvalid[i] & tready[i] & ~rst[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one beat once tready is up and queue its expected outcome
  task automatic send(input int i, input logic [31:0] d, input logic e_lk, input logic e_ep,
                      input logic [31:0] e_ec, input logic [31:0] e_bc);
    int w;
    w = 0;
    while (!tready[i] && w < 20) begin
      tick();
      w++;
    end
    if (!tready[i]) begin
      n_chk++;
      n_fail++;
      $display("FAIL u%0d_tready_timeout: got tready=0 expected 1 within 20 cycles", i);
      return;
    end
    if (i == 2) begin
      if (have_prev) chk("u2_ready_period", 32'(cyc - prev_cyc), 32'd4);
      prev_cyc  = cyc;
      have_prev = 1;
    end
    td[i]     = d;
    tvalid[i] = 1'b1;
    sbq[i].push_back('{lk: e_lk, ep: e_ep, ec: e_ec, bc: e_bc, ld: d});
    tick();
    tvalid[i] = 1'b0;
  endtask

  task automatic chk_reset_vals(input int i, input string tag);
    chk($sformatf("u%0d_%s_tready", i, tag), 32'(tready[i]), 32'd0);
    chk($sformatf("u%0d_%s_locked", i, tag), 32'(lk[i]), 32'd0);
    chk($sformatf("u%0d_%s_error_pulse", i, tag), 32'(ep[i]), 32'd0);
    chk($sformatf("u%0d_%s_error_count", i, tag), ec[i], 32'd0);
    chk($sformatf("u%0d_%s_beat_count", i, tag), bc[i], 32'd0);
    chk($sformatf("u%0d_%s_last_data", i, tag), ld[i], 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] wrap_seq [25];
    int bcnt;
    wrap_seq = '{0, 7, 14, 21, 1, 8, 15, 22, 2, 9, 16, 23, 3, 10, 17, 24,
                 4, 11, 18, 25, 5, 12, 19, 26, 6};
    for (int i = 0; i < 3; i++) td[i] = 32'd0;
    repeat (3) tick();
    rst = 3'b000;
    tick();
    for (int i = 0; i < 3; i++) chk_reset_vals(i, "reset");

    // default instance: continuous stream 0..255 twice
    en[0] = 1'b1;
    tick();
    chk("u0_tready_after_enable", 32'(tready[0]), 32'd1);
    for (int k = 0; k < 512; k++) send(0, 32'(k % 256), 1'b1, 1'b0, 32'd0, 32'(k + 1));
    chk("u0_beat_count_512", bc[0], 32'd512);
    bcnt = 512;

    // dropped value 17
    for (int v = 0; v <= 16; v++) begin
      bcnt++;
      send(0, 32'(v), 1'b1, 1'b0, 32'd0, 32'(bcnt));
    end
    bcnt++;
    send(0, 32'd18, 1'b1, 1'b1, 32'd1, 32'(bcnt));
    bcnt++;
    send(0, 32'd19, 1'b1, 1'b0, 32'd1, 32'(bcnt));

    // clear with no beat
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("u0_clear_error_count", ec[0], 32'd0);
    chk("u0_clear_beat_count", bc[0], 32'd0);

    // four garbage words drop lock on the fourth, then relock on 5
    for (int k = 0; k < 4; k++) send(0, 32'hDEAD, (k < 3), 1'b1, 32'(k + 1), 32'(k + 1));
    send(0, 32'd5, 1'b1, 1'b0, 32'd4, 32'd5);
    send(0, 32'd6, 1'b1, 1'b0, 32'd4, 32'd6);
    send(0, 32'd7, 1'b1, 1'b0, 32'd4, 32'd7);

    // clear concurrent with a mismatch: counters zero, pulse still fires
    clr[0] = 1'b1;
    send(0, 32'd100, 1'b1, 1'b1, 32'd0, 32'd0);
    clr[0] = 1'b0;

    // enable falls during a matching beat: beat counted, lock dropped, tready off
    en[0] = 1'b0;
    send(0, 32'd101, 1'b0, 1'b0, 32'd0, 32'd1);
    chk("u0_tready_after_disable", 32'(tready[0]), 32'd0);
    en[0] = 1'b1;
    tick();
    send(0, 32'd102, 1'b1, 1'b0, 32'd0, 32'd2);

    // reset with a beat in flight
    td[0]     = 32'd103;
    tvalid[0] = 1'b1;
    rst[0]    = 1'b1;
    tick();
    rst[0]    = 1'b0;
    tvalid[0] = 1'b0;
    chk_reset_vals(0, "midreset");

    // overshoot wrap instance: out-of-range first word, then the sequence
    en[1] = 1'b1;
    tick();
    send(1, 32'd30, 1'b0, 1'b0, 32'd0, 32'd1);
    for (int k = 0; k < 25; k++) send(1, wrap_seq[k], 1'b1, 1'b0, 32'd0, 32'(k + 2));

    // throttled instance: generator-paced stream of 100 beats
    en[2] = 1'b1;
    tick();
    for (int k = 0; k < 100; k++) send(2, 32'(k), 1'b1, 1'b0, 32'd0, 32'(k + 1));

    repeat (3) tick();
    for (int i = 0; i < 3; i++) chk($sformatf("u%0d_sb_drained", i), 32'(sbq[i].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
